// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBus types plus the definitions used by the on-chip RAM responder.
package cbus_ram_responder_pkg;

   localparam int CBUS_ADDR_W     = 64;
   localparam int CBUS_DATA_W     = 64;
   localparam int CBUS_WORD_BYTES = 8;

   typedef logic [1:0] axi_burst_t;

   localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
   localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
   localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

   // Transfer size per beat (informational for this responder).
   typedef enum logic [2:0] {
      MSIZE1   = 3'd0,
      MSIZE2   = 3'd1,
      MSIZE4   = 3'd2,
      MSIZE8   = 3'd3,
      MSIZE16  = 3'd4,
      MSIZE32  = 3'd5,
      MSIZE64  = 3'd6,
      MSIZE128 = 3'd7
   } msize_t;

   // Burst length encoded as number of beats minus one.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef struct packed {
      logic                         valid;
      logic                         is_write;
      msize_t                       size;
      logic [CBUS_ADDR_W-1:0]       addr;
      logic [CBUS_WORD_BYTES-1:0]   strobe;
      logic [CBUS_DATA_W-1:0]       data;
      mlen_t                        len;
      axi_burst_t                   burst;
   } cbus_req_t;

   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [CBUS_DATA_W-1:0] data;
   } cbus_resp_t;

   // Responder transaction phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      BEAT = 2'd2,
      DONE = 2'd3
   } rsp_state_t;

endpackage

// File: rtl/cbus_ram_responder_bank.sv
// Word-wide RAM bank with per-byte write enables and a registered read port.
module cbus_ram_bank #(
   parameter int DEPTH = 4096,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wstrb,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);

   logic [63:0] mem [DEPTH];

   // Byte lanes are written only where the strobe bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered read: data for the index presented this cycle appears next cycle.
   always_ff @(posedge clk) begin
      rdata <= mem[idx];
   end

endmodule

// File: rtl/cbus_ram_responder.sv
// CBus slave backed by an on-chip word array, with bursts and fixed wait states.
module cbus_ram_responder
   import cbus_ram_responder_pkg::*;
#(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  cbus_req_t   oreq,
   output cbus_resp_t  oresp,
   output logic        busy,
   output logic [31:0] txn_cnt,
   output logic [15:0] err_cnt
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'(CBUS_WORD_BYTES);
   localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   rsp_state_t       state;
   rsp_state_t       state_nxt;

   logic             lat_write;
   logic             lat_fixed;
   logic             lat_oor;
   logic [3:0]       lat_len;
   logic [3:0]       beat_cnt;
   logic [3:0]       wait_cnt;
   logic [IDX_W-1:0] cur_idx;

   logic [63:0]      addr_off;
   logic [IDX_W-1:0] req_idx;
   logic             req_oor;
   logic [IDX_W-1:0] next_idx;
   logic             is_last;

   logic             bank_we;
   logic [IDX_W-1:0] bank_idx;
   logic [63:0]      bank_rdata;

   // Decode the incoming start address into a word index and an in-range flag.
   always_comb begin
      addr_off = oreq.addr - BASE;
      req_idx  = IDX_W'(addr_off >> 3);
      req_oor  = (oreq.addr < BASE) || (oreq.addr >= LIMIT);
      next_idx = lat_fixed ? cur_idx : cur_idx + IDX_W'(1);
      is_last  = (beat_cnt == lat_len);
   end

   // State register; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a master dropping valid mid-transaction aborts it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (oreq.valid) begin
               state_nxt = (LATENCY > 0) ? WAIT : BEAT;
            end
         end
         WAIT: begin
            if (!oreq.valid) begin
               state_nxt = IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_nxt = BEAT;
            end
         end
         BEAT: begin
            if (!oreq.valid) begin
               state_nxt = IDLE;
            end else if (is_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture the request at acceptance, then step the wait counter and beat address.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lat_write <= 1'b0;
         lat_fixed <= 1'b0;
         lat_oor   <= 1'b0;
         lat_len   <= 4'd0;
         beat_cnt  <= 4'd0;
         wait_cnt  <= 4'd0;
         cur_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (oreq.valid) begin
                  lat_write <= oreq.is_write;
                  lat_fixed <= (oreq.burst == AXI_BURST_FIXED);
                  lat_oor   <= req_oor;
                  lat_len   <= 4'(oreq.len);
                  beat_cnt  <= 4'd0;
                  wait_cnt  <= LAT_LOAD;
                  cur_idx   <= req_idx;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            BEAT: begin
               if (oreq.valid && !is_last) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  cur_idx  <= next_idx;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Completed-transaction and out-of-range counters, updated on the final beat.
   always_ff @(posedge clk) begin
      if (!reset) begin
         txn_cnt <= 32'd0;
         err_cnt <= 16'd0;
      end else if ((state == BEAT) && oreq.valid && is_last) begin
         txn_cnt <= txn_cnt + 32'd1;
         if (lat_oor && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

   // Bank port: reads prefetch one cycle ahead of the beat; writes target the current beat.
   always_comb begin
      bank_we  = 1'b0;
      bank_idx = req_idx;
      case (state)
         IDLE: bank_idx = req_idx;
         WAIT: bank_idx = cur_idx;
         BEAT: begin
            bank_idx = lat_write ? cur_idx : next_idx;
            bank_we  = lat_write && !lat_oor && oreq.valid && reset;
         end
         DONE: bank_idx = cur_idx;
         default: bank_idx = req_idx;
      endcase
   end

   cbus_ram_bank #(
      .DEPTH (DEPTH)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .idx   (bank_idx),
      .wstrb (oreq.strobe),
      .wdata (oreq.data),
      .rdata (bank_rdata)
   );

   // Response is purely a function of the phase; data only for in-range read beats.
   always_comb begin
      oresp       = '0;
      oresp.ready = (state == BEAT);
      oresp.last  = (state == BEAT) && is_last;
      if ((state == BEAT) && !lat_write && !lat_oor) begin
         oresp.data = bank_rdata;
      end
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench with a transaction-level memory model and a per-cycle compare process.
module tb_cbus_ram_responder;
   import cbus_ram_responder_pkg::*;

   localparam logic [63:0] BASE    = 64'h8000_0000;
   localparam int          DEPTH   = 4096;
   localparam int          LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset;
   cbus_req_t   oreq;
   cbus_resp_t  oresp;
   logic        busy;
   logic [31:0] txn_cnt;
   logic [15:0] err_cnt;

   typedef struct {
      int          cyc;
      bit          busy;
      bit          ready;
      bit          last;
      bit          chk_data;
      logic [63:0] data;
      int          txn;
      int          err;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [63:0] data;
      bit          last;
   } cap_t;

   exp_t        exp_q[$];
   cap_t        cap[$];
   exp_t        ce;
   logic [63:0] mem [DEPTH];
   bit          known [DEPTH];
   logic [63:0] wbuf [16];
   int          mdl_txn = 0;
   int          mdl_err = 0;
   int          last_txn = 0;
   int          last_err = 0;
   int          cyc = 0;
   bit          cmp_en = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   cbus_ram_responder #(
      .BASE    (BASE),
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .oreq    (oreq),
      .oresp   (oresp),
      .busy    (busy),
      .txn_cnt (txn_cnt),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [63:0] pat(input int w);
      return {16'hC0DE, 16'(w), 16'h5A5A, 16'(w)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // what: 0 = data, 1 = last flag, 2 = ready cycle offset from the acceptance cycle
   task automatic capCheck(input string name, input int k, input int what, input int c0,
                           input logic [63:0] exp);
      if (k < cap.size()) begin
         case (what)
            0: checkOutput(name, cap[k].data, exp);
            1: checkOutput(name, 64'(cap[k].last), exp);
            default: checkOutput(name, 64'(cap[k].cyc - c0), exp);
         endcase
      end else begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: beat %0d missing, got %0d beats", name, k, cap.size());
      end
   endtask

   // Per-cycle compare of all outputs against the model schedule.
   always @(negedge clk) begin
      if (cmp_en) begin
         ce = '{default: 0};
         ce.txn = last_txn;
         ce.err = last_err;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checkOutput("sched_stale", 64'(cyc), 64'(exp_q[0].cyc));
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ce = exp_q.pop_front();
            last_txn = ce.txn;
            last_err = ce.err;
         end
         checkOutput("busy", 64'(busy), 64'(ce.busy));
         checkOutput("ready", 64'(oresp.ready), 64'(ce.ready));
         checkOutput("last", 64'(oresp.last), 64'(ce.last));
         checkOutput("txn_cnt", 64'(txn_cnt), 64'(ce.txn));
         checkOutput("err_cnt", 64'(err_cnt), 64'(ce.err));
         if (!ce.ready) begin
            checkOutput("data_idle", oresp.data, 64'd0);
         end else if (ce.chk_data) begin
            checkOutput("data_beat", oresp.data, ce.data);
         end
         if (oresp.ready === 1'b1) begin
            cap.push_back('{cyc: cyc, data: oresp.data, last: oresp.last});
         end
      end
   end

   // Issue one transaction from an idle cycle, schedule the model's expectations, and drive beats.
   task automatic applyStimulus(input bit wr, input logic [63:0] addr, input int nbeats,
                                input bit fixed, input logic [7:0] strb, input int cut_beat,
                                input bit cut_rst, output int c0);
      bit          inr;
      int          idx0;
      int          idx;
      int          nb_eff;
      logic [63:0] off;
      exp_t        e;
      c0     = cyc;
      inr    = (addr >= BASE) && (addr < BASE + 64'(DEPTH) * 64'd8);
      off    = (addr - BASE) >> 3;
      idx0   = int'(off % 64'(DEPTH));
      nb_eff = (cut_beat >= 0) ? cut_beat + 1 : nbeats;
      for (int w = 1; w <= LATENCY; w++) begin
         e = '{default: 0};
         e.cyc = c0 + w; e.busy = 1; e.txn = mdl_txn; e.err = mdl_err;
         exp_q.push_back(e);
      end
      for (int k = 0; k < nb_eff; k++) begin
         idx = fixed ? idx0 : (idx0 + k) % DEPTH;
         e = '{default: 0};
         e.cyc = c0 + LATENCY + 1 + k; e.busy = 1; e.ready = 1; e.last = (k == nbeats - 1);
         e.txn = mdl_txn; e.err = mdl_err;
         if (!wr) begin
            e.chk_data = !inr || known[idx];
            e.data     = inr ? mem[idx] : 64'd0;
         end
         exp_q.push_back(e);
         if (wr && inr) begin
            if (k == cut_beat) begin
               known[idx] = 1'b0;
            end else begin
               for (int i = 0; i < 8; i++) begin
                  if (strb[i]) mem[idx][8*i +: 8] = wbuf[k][8*i +: 8];
               end
               known[idx] = known[idx] || (strb == 8'hFF);
            end
         end
      end
      e = '{default: 0};
      if (cut_beat < 0) begin
         mdl_txn++;
         if (!inr && mdl_err < 65535) mdl_err++;
         e.cyc = c0 + LATENCY + nbeats + 1; e.busy = 1;
      end else begin
         if (cut_rst) begin
            mdl_txn = 0;
            mdl_err = 0;
         end
         e.cyc = c0 + LATENCY + nb_eff + 1;
      end
      e.txn = mdl_txn; e.err = mdl_err;
      exp_q.push_back(e);

      oreq.valid    = 1'b1;
      oreq.is_write = wr;
      oreq.size     = MSIZE8;
      oreq.addr     = addr;
      oreq.strobe   = strb;
      oreq.data     = wbuf[0];
      oreq.len      = mlen_t'(4'(nbeats - 1));
      oreq.burst    = fixed ? AXI_BURST_FIXED : AXI_BURST_INCR;
      repeat (LATENCY + 1) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < nb_eff; k++) begin
         oreq.data = wbuf[k];
         if (k == cut_beat) begin
            if (cut_rst) reset = 1'b0;
            else oreq.valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      oreq  = '0;
      reset = 1'b1;
      if (cut_beat < 0) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic doWrite(input logic [63:0] addr, input int nbeats, input bit fixed,
                          input logic [7:0] strb);
      int c0;
      applyStimulus(1'b1, addr, nbeats, fixed, strb, -1, 1'b0, c0);
   endtask

   task automatic doRead(input logic [63:0] addr, input int nbeats, input bit fixed, output int c0);
      cap.delete();
      applyStimulus(1'b0, addr, nbeats, fixed, 8'h00, -1, 1'b0, c0);
   endtask

   task automatic pulseReset();
      exp_t e;
      e = '{default: 0};
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      mdl_txn = 0;
      mdl_err = 0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      int c0;
      reset = 1'b0;
      oreq  = '0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      for (int i = 0; i < 16; i++) wbuf[i] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_ready", 64'(oresp.ready), 64'd0);
      checkOutput("rst_last", 64'(oresp.last), 64'd0);
      checkOutput("rst_data", oresp.data, 64'd0);
      checkOutput("rst_txn", 64'(txn_cnt), 64'd0);
      checkOutput("rst_err", 64'(err_cnt), 64'd0);
      reset  = 1'b1;
      cmp_en = 1'b1;

      for (int k = 0; k < 8; k++) wbuf[k] = pat(k);
      doWrite(BASE, 8, 1'b0, 8'hFF);
      wbuf[0] = 64'hDEAD_BEEF_0123_4567;
      doWrite(BASE, 1, 1'b0, 8'hFF);
      wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD;
      doWrite(BASE + 64'h10, 1, 1'b0, 8'hFF);
      wbuf[0] = pat(DEPTH - 2);
      wbuf[1] = pat(DEPTH - 1);
      doWrite(BASE + 64'(DEPTH - 2) * 64'd8, 2, 1'b0, 8'hFF);
      for (int k = 0; k < 8; k++) wbuf[k] = pat(16 + k);
      doWrite(BASE + 64'd128, 8, 1'b0, 8'hFF);
      pulseReset();
      checkOutput("rst_clears_txn", 64'(txn_cnt), 64'd0);

      // single read with hand-computed latency
      doRead(BASE, 1, 1'b0, c0);
      checkOutput("rd1_beats", 64'(cap.size()), 64'd1);
      capCheck("rd1_data", 0, 0, c0, 64'hDEAD_BEEF_0123_4567);
      capCheck("rd1_last", 0, 1, c0, 64'd1);
      capCheck("rd1_latency", 0, 2, c0, 64'd3);
      checkOutput("rd1_txn", 64'(txn_cnt), 64'd1);

      // partial-strobe write and read-back
      wbuf[0] = 64'h1111_2222_3333_4444;
      doWrite(BASE + 64'h10, 1, 1'b0, 8'h0F);
      doRead(BASE + 64'h10, 1, 1'b0, c0);
      capCheck("strobe_merge", 0, 0, c0, 64'hAAAA_BBBB_3333_4444);

      // INCR read wrapping across the end of the array
      doRead(BASE + 64'(DEPTH - 2) * 64'd8, 4, 1'b0, c0);
      checkOutput("wrap_beats", 64'(cap.size()), 64'd4);
      capCheck("wrap_d0", 0, 0, c0, pat(DEPTH - 2));
      capCheck("wrap_d1", 1, 0, c0, pat(DEPTH - 1));
      capCheck("wrap_d2", 2, 0, c0, 64'hDEAD_BEEF_0123_4567);
      capCheck("wrap_d3", 3, 0, c0, pat(1));
      for (int k = 0; k < 4; k++) begin
         capCheck("wrap_last", k, 1, c0, (k == 3) ? 64'd1 : 64'd0);
         capCheck("wrap_cycle", k, 2, c0, 64'(3 + k));
      end

      // FIXED write burst lands every beat on one word
      for (int k = 0; k < 4; k++) wbuf[k] = 64'(k + 1);
      doWrite(BASE + 64'h20, 4, 1'b1, 8'hFF);
      doRead(BASE + 64'h20, 4, 1'b0, c0);
      capCheck("fixed_w4", 0, 0, c0, 64'h4);
      capCheck("fixed_w5", 1, 0, c0, pat(5));
      capCheck("fixed_w6", 2, 0, c0, pat(6));
      capCheck("fixed_w7", 3, 0, c0, pat(7));

      // out-of-range read and write
      doRead(64'h7FFF_FFF8, 1, 1'b0, c0);
      capCheck("oor_rd_data", 0, 0, c0, 64'd0);
      capCheck("oor_rd_latency", 0, 2, c0, 64'd3);
      checkOutput("oor_rd_err", 64'(err_cnt), 64'd1);
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      doWrite(64'h7FFF_FFF8, 1, 1'b0, 8'hFF);
      checkOutput("oor_wr_err", 64'(err_cnt), 64'd2);
      doRead(BASE + 64'(DEPTH - 2) * 64'd8, 4, 1'b0, c0);
      capCheck("oor_keep_d0", 0, 0, c0, pat(DEPTH - 2));
      capCheck("oor_keep_d1", 1, 0, c0, pat(DEPTH - 1));
      capCheck("oor_keep_d2", 2, 0, c0, 64'hDEAD_BEEF_0123_4567);
      doRead(BASE + 64'(DEPTH) * 64'd8, 1, 1'b0, c0);
      capCheck("oor_top_data", 0, 0, c0, 64'd0);
      checkOutput("oor_top_err", 64'(err_cnt), 64'd3);
      checkOutput("txn_after_oor", 64'(txn_cnt), 64'd10);

      // master drops valid during the second beat
      cap.delete();
      applyStimulus(1'b0, BASE + 64'h20, 4, 1'b0, 8'h00, 1, 1'b0, c0);
      checkOutput("abort_beats", 64'(cap.size()), 64'd2);
      checkOutput("abort_txn", 64'(txn_cnt), 64'd10);
      checkOutput("abort_busy", 64'(busy), 64'd0);

      // reset during the second beat of an eight-beat write
      for (int k = 0; k < 8; k++) wbuf[k] = 64'hFEED_0000_0000_0000 | 64'(k);
      applyStimulus(1'b1, BASE + 64'd128, 8, 1'b0, 8'hFF, 1, 1'b1, c0);
      checkOutput("mid_rst_ready", 64'(oresp.ready), 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_txn", 64'(txn_cnt), 64'd0);
      checkOutput("mid_rst_err", 64'(err_cnt), 64'd0);
      doRead(BASE + 64'd128, 8, 1'b0, c0);
      capCheck("mid_rst_beat1", 0, 0, c0, 64'hFEED_0000_0000_0000);
      for (int k = 2; k < 8; k++) begin
         capCheck("mid_rst_untouched", k, 0, c0, pat(16 + k));
      end

      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("sched_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
